reg_file: RTL and testbench

//   8-entry x 8-bit general-purpose register file for the simple 8-bit CPU datapath.
//   Two combinational read ports feed the ALU operands; one clocked write port takes
//   the ALU/memory result. Sits between instruction decode and the ALU.

---
 rtl/reg_file.sv | 58 +++++
 tb/tb_reg_file.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// 8 x 8 register file: two combinational read ports, one clocked write port, async clear.
// Define REGFILE_SIM_DELAY_EN to add the datapath timing-model delays (simulation only).
module reg_file #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    input  logic [ADDR_W-1:0] inaddress,
    input  logic [ADDR_W-1:0] out1address,
    input  logic [ADDR_W-1:0] out2address,
    input  logic              write,
    input  logic              clk,
    input  logic              reset
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  wen;

    // One-hot write decode; an X on write evaluates false in the if below.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wdec
            assign wen[gi] = write && (inaddress == ADDR_W'(gi));
        end
    endgenerate

`ifdef REGFILE_SIM_DELAY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs_reg[i] <= #1 '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wen[i]) regs_reg[i] <= #1 in;
            end
        end
    end

    assign #2 out1 = regs_reg[out1address];
    assign #2 out2 = regs_reg[out2address];
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs_reg[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wen[i]) regs_reg[i] <= in;
            end
        end
    end

    // No bypass from in: a same-index read shows the old value until the edge.
    assign out1 = regs_reg[out1address];
    assign out2 = regs_reg[out2address];
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random traffic against an array model.
module tb_reg_file;
    logic [7:0] in;
    logic [7:0] out1;
    logic [7:0] out2;
    logic [2:0] inaddress;
    logic [2:0] out1address;
    logic [2:0] out2address;
    logic       write;
    logic       clk;
    logic       reset;

    int tests = 0;
    int fails = 0;
    logic [7:0] model [8];

    reg_file dut (
        .in(in), .out1(out1), .out2(out2),
        .inaddress(inaddress), .out1address(out1address), .out2address(out2address),
        .write(write), .clk(clk), .reset(reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sweep every register through both read ports and compare with the model.
    task automatic check_all(input string tag);
        for (int a = 0; a < 8; a++) begin
            out1address = 3'(a);
            out2address = 3'(7 - a);
            #1;
            check($sformatf("%s out1 r%0d", tag, a), out1, model[a]);
            check($sformatf("%s out2 r%0d", tag, 7 - a), out2, model[7 - a]);
        end
    endtask

    // One write-port cycle: drive on negedge, let the posedge act, update the model.
    task automatic step(input logic wr, input logic [2:0] wa, input logic [7:0] wd);
        @(negedge clk);
        write = wr; inaddress = wa; in = wd;
        @(posedge clk);
        if (wr === 1'b1 && reset === 1'b0) model[wa] = wd;
        #1;
    endtask

    initial begin
        logic [7:0] rd;
        logic [2:0] ra;
        logic       rw;
        for (int a = 0; a < 8; a++) model[a] = 8'd0;
        reset = 1'b1; write = 1'b0; in = 8'd0; inaddress = 3'd0;
        out1address = 3'd0; out2address = 3'd4;

        // 1. reset
        @(posedge clk); #1;
        check("reset out1 a0", out1, 8'd0);
        check("reset out2 a4", out2, 8'd0);
        @(negedge clk); reset = 1'b0; #1;
        check("post-reset out1 a0", out1, 8'd0);
        check("post-reset out2 a4", out2, 8'd0);
        check_all("reset sweep");

        // 2. simple write
        step(1'b1, 3'd2, 8'd95);
        write = 1'b0; out1address = 3'd2; #1;
        check("write r2", out1, 8'd95);

        // 3. read-during-write, no bypass
        @(negedge clk);
        inaddress = 3'd1; in = 8'd28; write = 1'b1; out1address = 3'd1; #1;
        check("rdw old r1", out1, 8'd0);
        @(posedge clk); model[1] = 8'd28; #1;
        check("rdw new r1", out1, 8'd28);

        // 4. repeated writes: last edge wins
        out2address = 3'd4;
        step(1'b1, 3'd4, 8'd6);
        check("rewrite first r4", out2, 8'd6);
        step(1'b1, 3'd4, 8'd15);
        check("rewrite second r4", out2, 8'd15);

        // 5. address all-ones selects r7; WRITE low holds everything
        ra = '1;
        step(1'b1, ra, 8'd50);
        for (int k = 0; k < 3; k++) step(1'b0, ra, 8'd99);
        out1address = ra; out2address = 3'd2; #1;
        check("r7 hold", out1, 8'd50);
        check("r2 hold", out2, 8'd95);
        out1address = 3'd1; out2address = 3'd4; #1;
        check("r1 hold", out1, 8'd28);
        check("r4 hold", out2, 8'd15);
        check_all("after r7");

        // WRITE pulse strictly between edges is ignored
        @(negedge clk); #1;
        inaddress = 3'd0; in = 8'hAA; write = 1'b1; #2; write = 1'b0;
        @(posedge clk); #1;
        check_all("mid-cycle pulse");

        // X on WRITE at an edge is treated as no write
        step(1'bx, 3'd3, 8'h77);
        write = 1'b0;
        check_all("x write");

        // Random traffic; reads must show the old value before the edge
        for (int t = 0; t < 150; t++) begin
            @(negedge clk);
            rw = 1'($urandom_range(0, 1)); ra = 3'($urandom); rd = 8'($urandom);
            write = rw; inaddress = ra; in = rd;
            out1address = ra; out2address = 3'($urandom);
            #1;
            check($sformatf("rand%0d pre out1", t), out1, model[out1address]);
            check($sformatf("rand%0d pre out2", t), out2, model[out2address]);
            @(posedge clk);
            if (rw) model[ra] = rd;
            #1;
            check($sformatf("rand%0d post out1", t), out1, model[out1address]);
            check($sformatf("rand%0d post out2", t), out2, model[out2address]);
            $display("[TB] txn %0d we=%0d waddr=%0d wdata=%0d r1=%0d:%0d r2=%0d:%0d",
                     t, rw, ra, rd, out1address, out1, out2address, out2);
        end
        write = 1'b0;

        // 6. make sure state is non-zero, then async reset between edges
        step(1'b1, 3'd6, 8'hC3);
        step(1'b1, 3'd5, 8'h3C);
        out1address = 3'd6; out2address = 3'd5; #1;
        check("pre-reset r6", out1, 8'hC3);
        check("pre-reset r5", out2, 8'h3C);
        @(negedge clk); #2;
        reset = 1'b1;
        for (int a = 0; a < 8; a++) model[a] = 8'd0;
        #1;
        check("async reset r6", out1, 8'd0);
        check("async reset r5", out2, 8'd0);
        step(1'b1, 3'd5, 8'hFF);
        check_all("write during reset");
        @(negedge clk); reset = 1'b0; write = 1'b0; #1;
        check_all("after reset release");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
